// File: rtl/coffee_pkg.sv
// rtl/coffee_pkg.sv - shared coffee machine types and constants
package coffee_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEAT    = 3'd1,
        ST_CUP     = 3'd2,
        ST_GRIND   = 3'd3,
        ST_BREW    = 3'd4,
        ST_DONE    = 3'd5,
        ST_RELEASE = 3'd6,
        ST_FAULT   = 3'd7
    } brew_state_t;

    localparam int TICK_CNT_W       = 16;
    localparam int DEF_TICK_DIV     = 100000;
    localparam int DEF_GRIND_TICKS  = 3000;
    localparam int DEF_BREW_TICKS   = 8000;
    localparam int DEF_HEAT_TIMEOUT = 20000;
    localparam int DEF_CUP_TIMEOUT  = 2000;

    localparam logic [7:0] COFFEE_VAL = 8'd25;

endpackage

// File: rtl/step_timer.sv
// rtl/step_timer.sv - prescaled tick counter with terminal-count compare
module step_timer
    import coffee_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_clr,
    input  logic [TICK_CNT_W-1:0] i_n,
    output logic                  o_done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]         r_presc;
    logic [TICK_CNT_W-1:0] r_cnt;
    logic                  w_tick;
    logic [TICK_CNT_W:0]   w_cnt_inc;

    assign w_tick    = (r_presc == PRESC_LAST);
    assign w_cnt_inc = {1'b0, r_cnt} + {{TICK_CNT_W{1'b0}}, 1'b1};
    // Fires on the cycle whose tick brings the count to N, so a state lasts exactly N*TICK_DIV cycles.
    assign o_done    = w_tick && (w_cnt_inc == {1'b0, i_n});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_cnt   <= '0;
        end else if (i_clr) begin
            r_presc <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            if (w_tick && (r_cnt != '1)) begin
                r_cnt <= w_cnt_inc[TICK_CNT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/brew_sequencer.sv
// rtl/brew_sequencer.sv - steps the brew unit through heat, cup, grind and brew
module brew_sequencer
    import coffee_pkg::*;
#(
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int GRIND_TICKS  = DEF_GRIND_TICKS,
    parameter int BREW_TICKS   = DEF_BREW_TICKS,
    parameter int HEAT_TIMEOUT = DEF_HEAT_TIMEOUT,
    parameter int CUP_TIMEOUT  = DEF_CUP_TIMEOUT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       heater_ready,
    input  logic       cup_sensor,
    input  logic       fault_clr,
    output logic       heater_en,
    output logic       cup_drop,
    output logic       grinder_on,
    output logic       pump_on,
    output logic       coffee_out,
    output logic       busy,
    output logic       fault,
    output logic [2:0] step
);

    brew_state_t           r_state;
    brew_state_t           w_next;
    logic [TICK_CNT_W-1:0] w_n;
    logic                  w_done;
    logic                  w_clr;

    // Any state change restarts the timer so every duration counts from entry.
    assign w_clr = (w_next != r_state);
    assign step  = r_state;

    step_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_clr),
        .i_n    (w_n),
        .o_done (w_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_n = '1;
        case (r_state)
            ST_HEAT:  w_n = TICK_CNT_W'(HEAT_TIMEOUT);
            ST_CUP:   w_n = TICK_CNT_W'(CUP_TIMEOUT);
            ST_GRIND: w_n = TICK_CNT_W'(GRIND_TICKS);
            ST_BREW:  w_n = TICK_CNT_W'(BREW_TICKS);
            default:  w_n = '1;
        endcase
    end

    always_comb begin
        w_next     = r_state;
        heater_en  = 1'b0;
        cup_drop   = 1'b0;
        grinder_on = 1'b0;
        pump_on    = 1'b0;
        coffee_out = 1'b0;
        busy       = 1'b1;
        fault      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) w_next = ST_HEAT;
            end
            ST_HEAT: begin
                heater_en = 1'b1;
                if (heater_ready)  w_next = ST_CUP;
                else if (w_done)   w_next = ST_FAULT;
            end
            ST_CUP: begin
                heater_en = 1'b1;
                cup_drop  = 1'b1;
                if (cup_sensor)    w_next = ST_GRIND;
                else if (w_done)   w_next = ST_FAULT;
            end
            ST_GRIND: begin
                heater_en  = 1'b1;
                grinder_on = 1'b1;
                if (w_done) w_next = ST_BREW;
            end
            ST_BREW: begin
                heater_en = 1'b1;
                pump_on   = 1'b1;
                // Losing the cup outranks completion: never pour onto the drip tray.
                if (!cup_sensor)   w_next = ST_FAULT;
                else if (w_done)   w_next = ST_DONE;
            end
            ST_DONE: begin
                coffee_out = 1'b1;
                w_next     = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!start) w_next = ST_IDLE;
            end
            ST_FAULT: begin
                busy  = 1'b0;
                fault = 1'b1;
                if (fault_clr && !start) w_next = ST_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_brew_sequencer.sv
// tb/tb_brew_sequencer.sv - table-driven bench for brew_sequencer
module tb_brew_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       heater_ready;
    logic       cup_sensor;
    logic       fault_clr;
    logic       heater_en;
    logic       cup_drop;
    logic       grinder_on;
    logic       pump_on;
    logic       coffee_out;
    logic       busy;
    logic       fault;
    logic [2:0] step;

    // {heater_en, cup_drop, grinder_on, pump_on, coffee_out, busy, fault, step}
    localparam logic [9:0] O_IDLE  = 10'b0000000_000;
    localparam logic [9:0] O_HEAT  = 10'b1000010_001;
    localparam logic [9:0] O_CUP   = 10'b1100010_010;
    localparam logic [9:0] O_GRIND = 10'b1010010_011;
    localparam logic [9:0] O_BREW  = 10'b1001010_100;
    localparam logic [9:0] O_DONE  = 10'b0000110_101;
    localparam logic [9:0] O_REL   = 10'b0000010_110;
    localparam logic [9:0] O_FAULT = 10'b0000001_111;

    typedef struct {
        logic       start;
        logic       hr;
        logic       cup;
        logic       fclr;
        int         cycles;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_coffee = 0;

    brew_sequencer #(
        .TICK_DIV     (4),
        .GRIND_TICKS  (3),
        .BREW_TICKS   (5),
        .HEAT_TIMEOUT (10),
        .CUP_TIMEOUT  (6)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .heater_ready (heater_ready),
        .cup_sensor   (cup_sensor),
        .fault_clr    (fault_clr),
        .heater_en    (heater_en),
        .cup_drop     (cup_drop),
        .grinder_on   (grinder_on),
        .pump_on      (pump_on),
        .coffee_out   (coffee_out),
        .busy         (busy),
        .fault        (fault),
        .step         (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && coffee_out) n_coffee <= n_coffee + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [9:0] get_outs();
        return {heater_en, cup_drop, grinder_on, pump_on, coffee_out, busy, fault, step};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void add(input logic s, input logic h, input logic c, input logic f,
                                input int n, input logic [9:0] e);
        vec_t v;
        v.start = s; v.hr = h; v.cup = c; v.fclr = f; v.cycles = n; v.exp = e;
        vecs.push_back(v);
    endfunction

    initial begin
        int   c0;
        int   bad;
        logic found;

        // normal brew, start dropped mid-brew
        add(0,0,0,0, 1, O_IDLE);
        add(1,1,0,0, 1, O_HEAT);
        add(1,1,0,0, 1, O_CUP);
        add(1,1,0,0, 2, O_CUP);
        add(1,1,1,0, 1, O_GRIND);
        add(1,1,1,0,11, O_GRIND);
        add(1,1,1,0, 1, O_BREW);
        add(0,1,1,0,19, O_BREW);
        add(0,1,1,0, 1, O_DONE);
        add(0,1,1,0, 1, O_REL);
        add(0,1,1,0, 1, O_IDLE);
        // heater timeout, fault_clr ignored while start=1
        add(1,0,0,0, 1, O_HEAT);
        add(1,0,0,0,39, O_HEAT);
        add(1,0,0,0, 1, O_FAULT);
        add(1,0,0,1, 3, O_FAULT);
        add(0,0,0,1, 1, O_IDLE);
        add(0,0,0,0, 1, O_IDLE);
        // cup timeout
        add(1,1,0,0, 1, O_HEAT);
        add(1,1,0,0, 1, O_CUP);
        add(1,1,0,0,23, O_CUP);
        add(1,1,0,0, 1, O_FAULT);
        add(0,1,0,1, 1, O_IDLE);
        // cup removed at BREW cycle 7
        add(1,1,0,0, 1, O_HEAT);
        add(1,1,0,0, 1, O_CUP);
        add(1,1,1,0, 1, O_GRIND);
        add(1,1,1,0,11, O_GRIND);
        add(1,1,1,0, 1, O_BREW);
        add(1,1,1,0, 7, O_BREW);
        add(1,1,0,0, 1, O_FAULT);
        add(0,1,0,1, 1, O_IDLE);
        // simultaneous events on the final cycle of each timed state
        add(1,0,0,0, 1, O_HEAT);
        add(1,0,0,0,39, O_HEAT);
        add(1,1,0,0, 1, O_CUP);
        add(1,1,0,0,23, O_CUP);
        add(1,1,1,0, 1, O_GRIND);
        add(1,1,1,0,11, O_GRIND);
        add(1,1,1,0, 1, O_BREW);
        add(1,1,1,0,19, O_BREW);
        add(1,1,0,0, 1, O_FAULT);
        add(0,1,0,1, 1, O_IDLE);

        reset = 1'b1; start = 1'b0; heater_ready = 1'b0; cup_sensor = 1'b0; fault_clr = 1'b0;
        run_cycles(2);
        check("reset_state", 32'(get_outs()), 32'(O_IDLE));
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            start        = vecs[i].start;
            heater_ready = vecs[i].hr;
            cup_sensor   = vecs[i].cup;
            fault_clr    = vecs[i].fclr;
            run_cycles(vecs[i].cycles);
            check($sformatf("vec%0d", i), 32'(get_outs()), 32'(vecs[i].exp));
        end
        check("coffee_pulses_table", 32'(n_coffee), 32'd1);

        // held start keeps the sequencer parked in RELEASE
        c0 = n_coffee;
        start = 1'b1; heater_ready = 1'b1; cup_sensor = 1'b1; fault_clr = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            run_cycles(1);
            if (coffee_out) begin
                found = 1'b1;
                break;
            end
        end
        check("held_coffee_seen", 32'(found), 32'd1);
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            run_cycles(1);
            if (get_outs() !== O_REL) bad++;
        end
        check("held_release_cycles_bad", 32'(bad), 32'd0);
        check("held_coffee_count", 32'(n_coffee - c0), 32'd1);
        start = 1'b0;
        run_cycles(1);
        check("held_release_exit", 32'(get_outs()), 32'(O_IDLE));

        // async reset mid-GRIND
        start = 1'b1;
        run_cycles(3);
        run_cycles(3);
        check("pre_reset_grind", 32'(get_outs()), 32'(O_GRIND));
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outs", 32'(get_outs()), 32'(O_IDLE));
        run_cycles(1);
        reset = 1'b0;
        run_cycles(1);
        check("post_reset_heat", 32'(get_outs()), 32'(O_HEAT));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
